// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand-loader FSM states and ALU opcode constants.
package alu_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    ISSUE   = 2'd3
  } loader_state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_ADD2 = 3'd7;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Operand-loader bus: board-side switch/button inputs and the registered
// operand set handed to the ALU. master = loader, slave = board/ALU side.
interface alu_operand_loader_if #(
  parameter int N = 4
);
  import alu_pkg::*;

  logic [N-1:0]  data_in;
  logic [2:0]    sel_in;
  logic          cin_in;
  logic          enter;
  logic          clear;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic [2:0]    select;
  logic          cin;
  logic          op_valid;
  loader_state_t state;

  modport master (
    input  data_in, sel_in, cin_in, enter, clear,
    output A, B, select, cin, op_valid, state
  );

  modport slave (
    output data_in, sel_in, cin_in, enter, clear,
    input  A, B, select, cin, op_valid, state
  );

endinterface

// File: rtl/alu_operand_loader_button_conditioner.sv
// Enter-button conditioning: 2-flop synchronizer, optional debounce and a
// rising-edge detector producing a one-cycle press.
// Optional debounce is enabled with `define ALU_LOADER_DEBOUNCE_EN.
module button_conditioner #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enter_i,
  output logic press_o
);

  logic s1_q;
  logic s2_q;
  logic p_q;
  logic level;

  // Bring the asynchronous button level into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= enter_i;
      s2_q <= s1_q;
    end
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             deb_q;

  // Accept a new level only after it has differed from the debounced level
  // for DEB_CYCLES consecutive cycles; any return to agreement restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (s2_q == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_q <= s2_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = deb_q;
`else
  // The debounce window is meaningless without the debounce stage
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign level      = s2_q;
`endif

  // History of the conditioned level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= 1'b0;
    end else begin
      p_q <= level;
    end
  end

  assign press_o = level & ~p_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand loader: captures A, B, then select/cin one press at a time and
// presents them as a registered operand set with a one-cycle op_valid.
// Optional enter debounce: `define ALU_LOADER_DEBOUNCE_EN.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_loader_if.master bus
);

  loader_state_t state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [2:0]    sel_q, sel_d;
  logic          cin_q, cin_d;
  logic          issue;
  logic          press;

  button_conditioner #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst     (rst),
    .enter_i (bus.enter),
    .press_o (press)
  );

  // State and operand registers; reset discards any partial operand set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cin_q   <= cin_d;
    end
  end

  // Next state and captures; clear overrides any press and masks op_valid
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    cin_d   = cin_q;
    issue   = 1'b0;
    if (bus.clear) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = '0;
      cin_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (press) begin
            a_d     = bus.data_in;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            b_d     = bus.data_in;
            state_d = LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (press) begin
            sel_d   = bus.sel_in;
            cin_d   = bus.cin_in;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          // A press here is deliberately dropped
          issue   = 1'b1;
          state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.select   = sel_q;
  assign bus.cin      = cin_q;
  assign bus.op_valid = issue;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader (both default and debounced builds).
module tb_alu_operand_loader;
  import alu_pkg::*;

  localparam int N   = 4;
  localparam int DEB = 16;
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   ov_cnt;
  int   ov0;

  alu_operand_loader_if #(.N(N)) bus ();

  alu_operand_loader #(
    .N          (N),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.op_valid) ov_cnt <= ov_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise enter, confirm no capture one edge early and the capture on time
  task automatic do_press(input loader_state_t from_s, input loader_state_t to_s, input string tag);
    bus.enter = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    check_val({tag, "_early"}, 32'(bus.state), 32'(from_s));
    @(negedge clk);
    check_val({tag, "_cap"}, 32'(bus.state), 32'(to_s));
    bus.enter = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; ov_cnt = 0;
    rst = 1'b1;
    bus.data_in = '0; bus.sel_in = '0; bus.cin_in = 1'b0;
    bus.enter = 1'b0; bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_A",     32'(bus.A),        32'h0);
    check_val("rst_B",     32'(bus.B),        32'h0);
    check_val("rst_sel",   32'(bus.select),   32'h0);
    check_val("rst_cin",   32'(bus.cin),      32'h0);
    check_val("rst_ov",    32'(bus.op_valid), 32'h0);
    check_val("rst_state", 32'(bus.state),    32'(LOAD_A));
    rst = 1'b0;
    @(negedge clk);

    // Basic three-press sequence
    bus.data_in = 4'h5;
    do_press(LOAD_A, LOAD_B, "pA");
    check_val("seq_A", 32'(bus.A), 32'h5);
    settle();
    bus.data_in = 4'hA;
    do_press(LOAD_B, LOAD_OP, "pB");
    check_val("seq_B", 32'(bus.B), 32'hA);
    check_val("seq_A_hold", 32'(bus.A), 32'h5);
    settle();
    bus.sel_in = 3'd3; bus.cin_in = 1'b1; bus.data_in = 4'h0;
    ov0 = ov_cnt;
    do_press(LOAD_OP, ISSUE, "pOP");
    check_val("seq_sel", 32'(bus.select),   32'h3);
    check_val("seq_cin", 32'(bus.cin),      32'h1);
    check_val("seq_ov",  32'(bus.op_valid), 32'h1);
    check_val("seq_A2",  32'(bus.A),        32'h5);
    check_val("seq_B2",  32'(bus.B),        32'hA);
    @(negedge clk);
    check_val("seq_ov_off", 32'(bus.op_valid), 32'h0);
    check_val("seq_back",   32'(bus.state),    32'(LOAD_A));
    settle();
    check_val("seq_ov_cnt", 32'(ov_cnt - ov0), 32'h1);
    check_val("seq_A3",     32'(bus.A),        32'h5);

    // Held button yields one press
    bus.data_in = 4'hC;
    bus.enter = 1'b1;
    repeat (50) @(negedge clk);
    bus.enter = 1'b0;
    settle();
    check_val("hold_state", 32'(bus.state), 32'(LOAD_B));
    check_val("hold_A",     32'(bus.A),     32'hC);

    // Plain clear
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check_val("clr_state", 32'(bus.state), 32'(LOAD_A));
    check_val("clr_A",     32'(bus.A),     32'h0);

    // Clear coincident with a press in LOAD_B
    bus.data_in = 4'h7;
    do_press(LOAD_A, LOAD_B, "p7");
    check_val("p7_A", 32'(bus.A), 32'h7);
    settle();
    bus.data_in = 4'h6;
    bus.enter = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    bus.clear = 1'b1;
    ov0 = ov_cnt;
    @(negedge clk);
    bus.clear = 1'b0;
    check_val("cc_state", 32'(bus.state),  32'(LOAD_A));
    check_val("cc_A",     32'(bus.A),      32'h0);
    check_val("cc_B",     32'(bus.B),      32'h0);
    check_val("cc_sel",   32'(bus.select), 32'h0);
    check_val("cc_cin",   32'(bus.cin),    32'h0);
    bus.enter = 1'b0;
    settle();
    check_val("cc_ov_cnt", 32'(ov_cnt - ov0), 32'h0);
    check_val("cc_state2", 32'(bus.state),    32'(LOAD_A));

    // Clear during ISSUE masks op_valid
    bus.data_in = 4'h1;
    do_press(LOAD_A, LOAD_B, "ci1");
    settle();
    bus.data_in = 4'h2;
    do_press(LOAD_B, LOAD_OP, "ci2");
    settle();
    bus.sel_in = 3'd6; bus.cin_in = 1'b1;
    ov0 = ov_cnt;
    do_press(LOAD_OP, ISSUE, "ci3");
    bus.clear = 1'b1;
    #1;
    check_val("ci_ov", 32'(bus.op_valid), 32'h0);
    @(negedge clk);
    bus.clear = 1'b0;
    check_val("ci_state",  32'(bus.state),    32'(LOAD_A));
    check_val("ci_A",      32'(bus.A),        32'h0);
    check_val("ci_sel",    32'(bus.select),   32'h0);
    check_val("ci_ov_cnt", 32'(ov_cnt - ov0), 32'h0);
    settle();

    // Asynchronous reset in LOAD_OP
    bus.data_in = 4'h3;
    do_press(LOAD_A, LOAD_B, "r3");
    settle();
    bus.data_in = 4'h9;
    do_press(LOAD_B, LOAD_OP, "r9");
    check_val("r_B", 32'(bus.B), 32'h9);
    settle();
    rst = 1'b1;
    #1;
    check_val("ar_A",     32'(bus.A),     32'h0);
    check_val("ar_B",     32'(bus.B),     32'h0);
    check_val("ar_state", 32'(bus.state), 32'(LOAD_A));
    // Button held across reset release counts as one press
    bus.data_in = 4'hD;
    bus.enter = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_press(LOAD_A, LOAD_B, "rh");
    check_val("rh_A", 32'(bus.A), 32'hD);
    settle();

    // Enter still high through ISSUE is not a new press
    bus.data_in = 4'h2;
    do_press(LOAD_B, LOAD_OP, "is2");
    settle();
    bus.sel_in = 3'd5; bus.cin_in = 1'b0;
    bus.data_in = 4'hF;
    bus.enter = 1'b1;
    repeat (LAT) @(negedge clk);
    check_val("is_state", 32'(bus.state), 32'(ISSUE));
    repeat (10) @(negedge clk);
    bus.enter = 1'b0;
    settle();
    check_val("is_back", 32'(bus.state),  32'(LOAD_A));
    check_val("is_A",    32'(bus.A),      32'hD);
    check_val("is_B",    32'(bus.B),      32'h2);
    check_val("is_sel",  32'(bus.select), 32'h5);

`ifdef ALU_LOADER_DEBOUNCE_EN
    // Short glitch rejected, long pulse accepted
    bus.data_in = 4'h8;
    bus.enter = 1'b1;
    repeat (10) @(negedge clk);
    bus.enter = 1'b0;
    settle();
    check_val("gl_state", 32'(bus.state), 32'(LOAD_A));
    bus.enter = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    check_val("lp_early", 32'(bus.state), 32'(LOAD_A));
    @(negedge clk);
    check_val("lp_cap", 32'(bus.state), 32'(LOAD_B));
    check_val("lp_A",   32'(bus.A),     32'h8);
    repeat (20 - LAT) @(negedge clk);
    bus.enter = 1'b0;
    settle();
`else
    // Single-cycle pulse is a press
    bus.data_in = 4'h8;
    bus.enter = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
    repeat (LAT - 2) @(negedge clk);
    check_val("sp_early", 32'(bus.state), 32'(LOAD_A));
    @(negedge clk);
    check_val("sp_cap", 32'(bus.state), 32'(LOAD_B));
    check_val("sp_A",   32'(bus.A),     32'h8);
    settle();
`endif
    check_val("end_state", 32'(bus.state), 32'(LOAD_B));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
